dds_wave_engine: RTL



---
 rtl/dds_wave_engine.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/dds_wave_engine.sv
// DDS waveform engine: phase accumulator, wave/scale/output pipeline, wrap-synchronous config.
// Define DDS_SYNC_OUT_EN to add sync_out, a half-period trigger aligned with data_out.
module dds_wave_engine #(
    parameter int unsigned DW = 14,
    parameter int unsigned PW = 32,
    parameter int unsigned FW = 24,
    parameter int unsigned LW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          single,
    input  logic          cfg_load,
    input  logic [2:0]    wave_sel,
    input  logic [FW-1:0] freq_word,
    input  logic [DW-1:0] duty,
    input  logic [DW-1:0] amp,
`ifdef DDS_SYNC_OUT_EN
    output logic          sync_out,
`endif
    output logic          busy,
    output logic          wrap,
    output logic          done,
    output logic [DW-1:0] data_out
);

    localparam int unsigned  RomDepth = 2 ** LW;
    localparam logic [DW-1:0] MID     = {1'b1, {(DW - 1){1'b0}}};

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    typedef struct packed {
        logic [2:0]    wave;
        logic [FW-1:0] freq;
        logic [DW-1:0] duty;
        logic [DW-1:0] amp;
    } cfg_t;

    // Quarter-wave table with a half-step offset so mirrored quadrants never repeat a sample.
    function automatic logic [DW-2:0] sine_entry(int unsigned idx);
        real x;
        x = 1.5707963267948966 * (real'(idx) + 0.5) / real'(RomDepth);
        return (DW - 1)'($rtoi($sin(x) * real'(2 ** (DW - 1) - 1) + 0.5));
    endfunction

    logic [DW-2:0] sine_rom [RomDepth];
    for (genvar gi = 0; gi < RomDepth; gi++) begin : g_rom
        assign sine_rom[gi] = sine_entry(gi);
    end

    state_e        state_q;
    logic [PW-1:0] acc_q;
    logic          single_q;
    logic          stop_pend_q;
    cfg_t          sh_q;
    cfg_t          act_q;
    cfg_t          cfg_in;
    logic [DW-1:0] raw_q;
    logic [DW-1:0] amp_p_q;
    logic [DW-1:0] scaled_q;
    logic [2:0]    end_pipe_q;
`ifdef DDS_SYNC_OUT_EN
    logic [1:0]    sync_p_q;
`endif

    logic [PW:0]     acc_sum;
    logic            run;
    logic            carry;
    logic            end_evt;
    logic            abort_evt;
    logic [DW-1:0]   ph;
    logic [LW-1:0]   rom_addr;
    logic [DW-2:0]   rom_val;
    logic [DW-1:0]   wave_val;
    logic signed [DW:0]      diff;
    logic signed [2*DW+1:0]  prod;
    logic [DW-1:0]   scaled;

    assign cfg_in    = '{wave: wave_sel, freq: freq_word, duty: duty, amp: amp};
    assign acc_sum   = {1'b0, acc_q} + {{(PW + 1 - FW){1'b0}}, act_q.freq};
    assign run       = (state_q == StRun);
    assign carry     = acc_sum[PW];
    // A stop on the wrap cycle itself ends at that wrap.
    assign end_evt   = run & carry & (single_q | stop_pend_q | stop);
    // With a zero increment no wrap ever comes, so stop must end the run directly.
    assign abort_evt = run & stop & (act_q.freq == '0);
    assign ph        = acc_q[PW-1 -: DW];

    always_comb begin
        rom_addr = ph[DW-3 -: LW];
        rom_val  = sine_rom[ph[DW-2] ? ~rom_addr : rom_addr];
        wave_val = MID;
        if (run) begin
            unique case (act_q.wave)
                3'b001:  wave_val = ph[DW-1] ? MID - {1'b0, rom_val} : MID + {1'b0, rom_val};
                3'b010:  wave_val = ph;
                3'b011:  wave_val = ph[DW-1] ? ~{ph[DW-2:0], 1'b0} : {ph[DW-2:0], 1'b0};
                3'b100:  wave_val = (ph < act_q.duty) ? '1 : '0;
                default: wave_val = MID;
            endcase
        end
    end

    always_comb begin
        diff   = $signed({1'b0, raw_q}) - $signed({1'b0, MID});
        prod   = diff * $signed({1'b0, amp_p_q});
        scaled = (&amp_p_q) ? raw_q : MID + DW'(prod >>> DW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            single_q    <= 1'b0;
            stop_pend_q <= 1'b0;
            sh_q        <= '0;
            act_q       <= '0;
            raw_q       <= MID;
            amp_p_q     <= '0;
            scaled_q    <= MID;
            data_out    <= MID;
            end_pipe_q  <= '0;
            busy        <= 1'b0;
            wrap        <= 1'b0;
            done        <= 1'b0;
`ifdef DDS_SYNC_OUT_EN
            sync_p_q    <= '0;
            sync_out    <= 1'b0;
`endif
        end else begin
            wrap       <= 1'b0;
            // done trails the end event so it lines up with the output pipeline.
            end_pipe_q <= {end_pipe_q[1:0], end_evt};
            done       <= end_pipe_q[2] | abort_evt;

            if (cfg_load) begin
                sh_q <= cfg_in;
            end
            if (!run && cfg_load) begin
                act_q <= cfg_in;
            end else if (run && carry) begin
                act_q <= cfg_load ? cfg_in : sh_q;
            end

            unique case (state_q)
                StIdle: begin
                    acc_q <= '0;
                    if (start) begin
                        state_q     <= StRun;
                        busy        <= 1'b1;
                        single_q    <= single;
                        stop_pend_q <= 1'b0;
                    end
                end
                StRun: begin
                    wrap <= carry;
                    if (end_evt || abort_evt) begin
                        state_q     <= StIdle;
                        busy        <= 1'b0;
                        acc_q       <= '0;
                        stop_pend_q <= 1'b0;
                    end else begin
                        acc_q <= acc_sum[PW-1:0];
                        if (stop) begin
                            stop_pend_q <= 1'b1;
                        end
                    end
                end
            endcase

            raw_q    <= wave_val;
            amp_p_q  <= act_q.amp;
            scaled_q <= scaled;
            data_out <= scaled_q;
`ifdef DDS_SYNC_OUT_EN
            sync_p_q <= {sync_p_q[0], run & ph[DW-1]};
            sync_out <= sync_p_q[1];
`endif
        end
    end

endmodule
